// File: rtl/result_stack_pkg.sv
// Shared constants and helpers for the result stack and its interface.
package result_stack_pkg;

    // Full-stack policy selectors for the OVERWRITE parameter.
    localparam int MODE_REJECT = 0;
    localparam int MODE_RING   = 1;

    // Operation resolved from the push/pop events of one cycle.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } op_e;

    // Width of the occupancy count, which must be able to hold DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/result_stack_if.sv
// Request/status bundle between the result producer and the result stack.
interface result_stack_if #(
    parameter int DATA_W = 6,
    parameter int TAG_W  = 3,
    parameter int DEPTH  = 9
) ();
    import result_stack_pkg::*;

    localparam int CNT_W = cnt_w(DEPTH);

    logic              push_req;
    logic              pop_req;
    logic              clear;
    logic              err_clr;
    logic [DATA_W-1:0] data_in;
    logic [TAG_W-1:0]  tag_in;
    logic [DATA_W-1:0] top_data;
    logic [TAG_W-1:0]  top_tag;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output push_req, pop_req, clear, err_clr, data_in, tag_in,
        input  top_data, top_tag, count, full, empty, overflow, underflow
    );

    modport slave (
        input  push_req, pop_req, clear, err_clr, data_in, tag_in,
        output top_data, top_tag, count, full, empty, overflow, underflow
    );

endinterface

// File: rtl/result_stack_edge_pulse.sv
// Rising-edge detector for an already synchronised button level. The sample
// register resets to 1 so a level held through reset release gives no pulse.
module edge_pulse (
    input  logic clk,
    input  logic reset_n,
    input  logic level_i,
    output logic pulse_o
);

    logic sample_q;

    // Remember last cycle's level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            sample_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~sample_q;

endmodule

// File: rtl/result_stack.sv
// LIFO of {tag, data} ALU results with edge-triggered push/pop, replace-top,
// optional overwrite-oldest when full, occupancy count and sticky error flags.
module result_stack
    import result_stack_pkg::*;
#(
    parameter int DATA_W    = 6,
    parameter int TAG_W     = 3,
    parameter int DEPTH     = 9,
    parameter int OVERWRITE = MODE_REJECT
) (
    input logic          clk,
    input logic          reset_n,
    result_stack_if.slave bus
);

    localparam int                CNT_W    = cnt_w(DEPTH);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] top_q,   top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q,  empty_q;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;
    entry_t           top_entry_q, top_entry_d;
    entry_t           entry_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ev, pop_ev;
    op_e              op;

    edge_pulse u_push_edge (.clk(clk), .reset_n(reset_n), .level_i(bus.push_req), .pulse_o(push_ev));
    edge_pulse u_pop_edge  (.clk(clk), .reset_n(reset_n), .level_i(bus.pop_req),  .pulse_o(pop_ev));

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? LAST_PTR : p - PTR_W'(1);
    endfunction

    // State register: pointer, count, flags and the registered top entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            top_q       <= LAST_PTR;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            top_entry_q <= '0;
        end else begin
            top_q       <= top_d;
            count_q     <= count_d;
            full_q      <= (count_d == FULL_CNT);
            empty_q     <= (count_d == '0);
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            top_entry_q <= top_entry_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the entry array has no reset; count and pointer alone decide which entries are valid.
        if (wr_en) begin
            mem_q[wr_ptr] <= entry_d;
        end
    end

    // Next state: clear first, then err_clr, then the resolved push/pop operation.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        op          = OP_IDLE;
        top_d       = top_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        wr_en       = 1'b0;
        wr_ptr      = ptr_inc(top_q);
        entry_d     = '{tag: bus.tag_in, data: bus.data_in};
        top_entry_d = '0;

        if (bus.clear) begin
            count_d = '0;
            top_d   = LAST_PTR;
        end else begin
            if (bus.err_clr) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            // Push+pop on an empty stack degrades to a plain push.
            if (push_ev && pop_ev && !empty_q) op = OP_REPLACE;
            else if (push_ev)                  op = OP_PUSH;
            else if (pop_ev)                   op = OP_POP;

            case (op)
                OP_REPLACE: begin
                    wr_en  = 1'b1;
                    wr_ptr = top_q;
                end
                OP_PUSH: begin
                    if (!full_q) begin
                        wr_en   = 1'b1;
                        top_d   = wr_ptr;
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                        // Ring mode: the slot above top is the oldest entry.
                        if (OVERWRITE == MODE_RING) begin
                            wr_en = 1'b1;
                            top_d = wr_ptr;
                        end
                    end
                end
                OP_POP: begin
                    if (!empty_q) begin
                        top_d   = ptr_dec(top_q);
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // New top entry, forwarded from the input when written this cycle.
        if (wr_en)               top_entry_d = entry_d;
        else if (count_d == '0)  top_entry_d = '0;
        else                     top_entry_d = mem_q[top_d];
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.top_data  = top_entry_q.data;
        bus.top_tag   = top_entry_q.tag;
        bus.count     = count_q;
        bus.full      = full_q;
        bus.empty     = empty_q;
        bus.overflow  = ovf_q;
        bus.underflow = unf_q;
    end

endmodule

// File: tb/tb_result_stack.sv
// Bench for result_stack: one reject-mode and one ring-mode instance share the
// same stimulus; a queue-based stack model feeds a per-instance scoreboard.
module tb_result_stack;
    import result_stack_pkg::*;

    localparam int DW  = 6;
    localparam int TW  = 3;
    localparam int DEP = 9;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic [3:0]    cnt;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          unf;
    } obs_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } ent_t;

    typedef struct {
        bit            p, q, c, e;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        logic [3:0]    cnt;
        logic [DW-1:0] top;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    result_stack_if #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEP)) if_rej ();
    result_stack_if #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEP)) if_ring ();

    result_stack #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEP), .OVERWRITE(MODE_REJECT))
        dut_rej (.clk(clk), .reset_n(reset_n), .bus(if_rej));
    result_stack #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEP), .OVERWRITE(MODE_RING))
        dut_ring (.clk(clk), .reset_n(reset_n), .bus(if_ring));

    ent_t  stk_rej[$], stk_ring[$];
    obs_t  sb_rej[$],  sb_ring[$];
    bit    ovf_m[2], unf_m[2];
    bit    prev_push, prev_pop;
    obs_t  rst_obs;
    vec_t  tbl[13];
    string phase;
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL [%s] %s: got 0x%0h, want 0x%0h", phase, name, act, exp);
    endtask

    function automatic obs_t observe(input bit ring);
        if (ring)
            return {if_ring.top_data, if_ring.top_tag, if_ring.count, if_ring.full,
                    if_ring.empty, if_ring.overflow, if_ring.underflow};
        return {if_rej.top_data, if_rej.top_tag, if_rej.count, if_rej.full,
                if_rej.empty, if_rej.overflow, if_rej.underflow};
    endfunction

    task automatic drive(input bit p, q, c, e, input logic [DW-1:0] d, input logic [TW-1:0] t);
        if_rej.push_req  = p; if_rej.pop_req  = q; if_rej.clear  = c; if_rej.err_clr  = e;
        if_rej.data_in   = d; if_rej.tag_in   = t;
        if_ring.push_req = p; if_ring.pop_req = q; if_ring.clear = c; if_ring.err_clr = e;
        if_ring.data_in  = d; if_ring.tag_in  = t;
    endtask

    task automatic model_reset();
        stk_rej.delete(); stk_ring.delete(); sb_rej.delete(); sb_ring.delete();
        ovf_m = '{0, 0}; unf_m = '{0, 0};
        prev_push = 1'b1; prev_pop = 1'b1;
    endtask

    // Behavioural stack: back of the queue is the top entry.
    task automatic model_apply(input bit ring, input bit pe, qe, clr, eclr, input ent_t e);
        ent_t s[$];
        obs_t o;
        int   m = ring ? 1 : 0;
        if (ring) s = stk_ring; else s = stk_rej;
        if (clr) begin
            s.delete();
        end else begin
            if (eclr) begin ovf_m[m] = 1'b0; unf_m[m] = 1'b0; end
            if (pe && qe && s.size() > 0) begin
                s[s.size()-1] = e;
            end else if (pe) begin
                if (s.size() < DEP) s.push_back(e);
                else begin
                    ovf_m[m] = 1'b1;
                    if (ring) begin void'(s.pop_front()); s.push_back(e); end
                end
            end else if (qe) begin
                if (s.size() > 0) void'(s.pop_back());
                else unf_m[m] = 1'b1;
            end
        end
        o       = '0;
        if (s.size() > 0) begin o.data = s[$].data; o.tag = s[$].tag; end
        o.cnt   = 4'(s.size());
        o.full  = (s.size() == DEP);
        o.empty = (s.size() == 0);
        o.ovf   = ovf_m[m];
        o.unf   = unf_m[m];
        if (ring) begin stk_ring = s; sb_ring.push_back(o); end
        else      begin stk_rej  = s; sb_rej.push_back(o);  end
    endtask

    // One clock: drive at negedge, predict, compare 1 time unit after posedge.
    task automatic step(input bit p, q, c, e, input logic [DW-1:0] d, input logic [TW-1:0] t);
        bit pe, qe;
        obs_t exp_o;
        @(negedge clk);
        drive(p, q, c, e, d, t);
        pe = p && !prev_push;
        qe = q && !prev_pop;
        prev_push = p;
        prev_pop  = q;
        model_apply(1'b0, pe, qe, c, e, '{data: d, tag: t});
        model_apply(1'b1, pe, qe, c, e, '{data: d, tag: t});
        @(posedge clk); #1;
        exp_o = sb_rej.pop_front();
        check("rej_state", observe(1'b0), exp_o);
        exp_o = sb_ring.pop_front();
        check("ring_state", observe(1'b1), exp_o);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, '0);
    endtask

    task automatic do_reset(input bit hold_push);
        @(negedge clk);
        reset_n = 1'b0;
        drive(hold_push, 0, 0, 0, '0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        prev_push = hold_push;
        prev_pop  = 1'b0;
        check("reset_rej",  observe(1'b0), rst_obs);
        check("reset_ring", observe(1'b1), rst_obs);
    endtask

    initial begin
        rst_obs       = '0;
        rst_obs.empty = 1'b1;
        drive(0, 0, 0, 0, '0, '0);
        model_reset();

        //            p  q  c  e   d   t  cnt top
        tbl[0]  = '{1, 0, 0, 0,  5, 1,  1,  5};
        tbl[1]  = '{0, 0, 0, 0,  0, 0,  1,  5};
        tbl[2]  = '{1, 1, 0, 0,  7, 2,  1,  7};
        tbl[3]  = '{0, 0, 0, 0,  0, 0,  1,  7};
        tbl[4]  = '{1, 0, 0, 0,  3, 3,  2,  3};
        tbl[5]  = '{0, 0, 0, 0,  0, 0,  2,  3};
        tbl[6]  = '{1, 0, 0, 0,  4, 4,  3,  4};
        tbl[7]  = '{0, 0, 0, 0,  0, 0,  3,  4};
        tbl[8]  = '{1, 0, 1, 0,  9, 5,  0,  0};
        tbl[9]  = '{0, 0, 0, 0,  0, 0,  0,  0};
        tbl[10] = '{0, 1, 0, 0,  0, 0,  0,  0};
        tbl[11] = '{0, 0, 0, 0,  0, 0,  0,  0};
        tbl[12] = '{0, 0, 0, 1,  0, 0,  0,  0};

        // Push level held through reset release must not push.
        phase = "held_push";
        do_reset(1'b1);
        step(1, 0, 0, 0, 6'd11, 3'd5);
        check("held_count", 32'(if_rej.count), 32'd0);
        check("held_empty", 32'(if_rej.empty), 32'd1);
        idle();
        step(1, 0, 0, 0, 6'd11, 3'd5);
        check("repress_count", 32'(if_rej.count), 32'd1);
        check("repress_top", 32'(if_rej.top_data), 32'd11);
        idle();

        // Fill, overflow in both policies, then drain.
        phase = "fill";
        do_reset(1'b0);
        for (int i = 1; i <= DEP; i++) begin
            step(1, 0, 0, 0, 6'(i), 3'((i - 1) % 8));
            idle();
        end
        check("full_flag", 32'(if_rej.full), 32'd1);
        check("full_count", 32'(if_rej.count), 32'd9);
        check("full_top", 32'(if_rej.top_data), 32'd9);
        step(1, 0, 0, 0, 6'd10, 3'd1);
        idle();
        check("rej_top_kept", 32'(if_rej.top_data), 32'd9);
        check("rej_overflow", 32'(if_rej.overflow), 32'd1);
        check("ring_top_new", 32'(if_ring.top_data), 32'd10);
        check("ring_count", 32'(if_ring.count), 32'd9);
        step(0, 0, 0, 1, '0, '0);
        check("errclr_ovf", 32'(if_rej.overflow), 32'd0);
        idle();
        phase = "drain";
        for (int k = 0; k < DEP; k++) begin
            check("ring_pop_order", 32'(if_ring.top_data), 32'(10 - k));
            step(0, 1, 0, 0, '0, '0);
            idle();
        end
        check("ring_empty", 32'(if_ring.empty), 32'd1);
        check("rej_empty", 32'(if_rej.empty), 32'd1);
        step(0, 1, 0, 0, '0, '0);
        check("ring_underflow", 32'(if_ring.underflow), 32'd1);
        check("rej_underflow", 32'(if_rej.underflow), 32'd1);
        idle();

        // Replace-top, clear beating a push edge, underflow, err_clr.
        phase = "table";
        do_reset(1'b0);
        foreach (tbl[i]) begin
            step(tbl[i].p, tbl[i].q, tbl[i].c, tbl[i].e, tbl[i].d, tbl[i].t);
            check($sformatf("tbl%0d_count", i), 32'(if_rej.count), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_top", i), 32'(if_rej.top_data), 32'(tbl[i].top));
        end

        // Asynchronous reset between clock edges.
        phase = "async_reset";
        do_reset(1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 0, 6'(20 + i), 3'(i));
            idle();
        end
        check("pre_reset_count", 32'(if_rej.count), 32'd4);
        #2 reset_n = 1'b0;
        #1;
        check("async_rej",  observe(1'b0), rst_obs);
        check("async_ring", observe(1'b1), rst_obs);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        prev_push = 1'b0;
        prev_pop  = 1'b0;
        step(1, 0, 0, 0, 6'd33, 3'd6);
        check("post_reset_push", 32'(if_rej.top_data), 32'd33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/result_stack.md
# result_stack

Parametrised last-in-first-out store for ALU results and their opcode tags, the successor to the fixed 6-bit × 9-entry result stack between the ALU and the seven-segment display driver. It generalises data width, tag width and depth. It adds these behaviours:
- built-in rising-edge detection of the push/pop button levels;
- simultaneous push/pop (replace-top);
- a selectable overwrite-oldest mode when full;
- an occupancy count;
- sticky error flags.

## Interface
- DATA_W, 6: result width in bits.
- TAG_W, 3: opcode tag width in bits.
- DEPTH, 9: number of entries, ≥2.
- OVERWRITE, 0: full-stack policy. 0 rejects the push. 1 discards the oldest entry.
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- push_req  in  1  push level; already synchronised and debounced.
- pop_req  in  1  pop level; already synchronised and debounced.
- clear  in  1  synchronous empty; level-sensitive.
- err_clr  in  1  clears the sticky error flags.
- data_in  in  DATA_W  result to push.
- tag_in  in  TAG_W  opcode tag to push.
- top_data  out  DATA_W  top entry's result; 0 when empty.
- top_tag  out  TAG_W  top entry's tag; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky; set by a push while full.
- underflow  out  1  sticky; set by a pop while empty.

## Operation
**Events**
- Push event = push_req high this cycle and low on the previous sample. Pop event is defined the same way on pop_req.
- Edge-sample registers reset to 1. A request held high through reset release therefore produces no event until it is released and pressed again.

**Storage**
- DEPTH-entry array of {tag, data}.
- Top pointer wraps modulo DEPTH; count saturates at DEPTH.

**Priority per cycle:** clear > err_clr/event processing. clear empties the stack and suppresses events in that cycle. err_clr clears both sticky flags; an error raised in the same cycle wins.

**Push only**
- Not full: write at top+1, count+1.
- Full, OVERWRITE=0: stack unchanged; overflow←1.
- Full, OVERWRITE=1: write at top+1 (mod DEPTH), which overwrites the oldest entry; count stays DEPTH; overflow←1.

**Pop only**
- Not empty: top−1 (mod DEPTH), count−1.
- Empty: no change; underflow←1.

**Push and pop in the same cycle**
- Not empty: the top entry is replaced by the input; count unchanged; no flags.
- Empty: treated as push only; no underflow.

Stack contents are not cleared on pop. Only pointers and count move.

## Timing
- All outputs are registered. Reset drives top_data/top_tag/count/overflow/underflow to 0, empty to 1 and full to 0.
- An event sampled at edge k updates every output after edge k, with no further latency. A back-to-back press requires at least one low sample between events.
- Reset asserted mid-operation clears all state at once, asynchronously. Deassertion is used synchronously.

## Structure
- Shared package/header `result_stack_pkg`: OVERWRITE mode constants (MODE_REJECT=0, MODE_RING=1) and a width function for count.
- Sub-module `edge_pulse`: rising-edge detector with reset-to-1 sample register, instantiated for push and pop.
- Top-level structure: pointer/count FSM plus the storage array. The storage array is a plain register array with no RAM inference requirement.

## Test plan
All scenarios use defaults unless stated.
- Reset with push_req held high, then release reset → no push; empty=1, count=0; after a low-then-high transition, one push occurs.
- Push 9 values 1..9 with tags 0..7,0 → full=1, count=9, top_data=9. A 10th push of 10 → top_data stays 9, overflow=1. err_clr → overflow=0.
- OVERWRITE=1, push 1..10 → count=9, top_data=10. Nine pops return 10,9,...,2, then empty=1. A further pop → underflow=1.
- Push 5, then push and pop in the same cycle with data_in=7 → count=1, top_data=7.
- Push 3 values, then assert clear together with a push edge → count=0, empty=1, top_data=0.
- Assert reset_n mid-sequence with count=4 → all outputs reach reset values before the next clk edge.
